// File: rtl/gon_bus.sv
// gon_bus: global-on-network read bus that routes one opsum from a PE to
// the controller per request. Each PE has a scan-loaded ID; a request
// carries a tag. The lowest-index PE whose ID equals the tag is selected.
// One opsum is then popped from that PE and held at the output until
// downstream takes it.
//
// Optional feature macro: GON_TIMEOUT_EN. When it is defined, WAIT gives
// up after TIMEOUT+1 cycles and returns an error response.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   set_id, id_scan_in  ID scan-chain shift enable / serial input
//   id_scan_out         scan-chain serial output (id_reg[0])
//   enable_tag          {req_enable, tag} read request
//   ready               request accepted on ready & req_enable
//   master_enable_data  per-PE {opsum_valid, opsum}
//   master_ready        per-PE opsum pop strobe
//   out_valid/out_data/out_err/out_ready  response handshake
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | bus free, ready for a request unless the chain is shifting
// WAIT  | PE selected, waiting for its opsum_valid to pop it
// HOLD  | response presented, waiting for out_ready

module gon_bus #(
    parameter int PE_NUMS    = 14,
    parameter int ID_LEN     = 4,
    parameter int PSUM_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_id,
    input  logic [ID_LEN-1:0]     id_scan_in,
    output logic [ID_LEN-1:0]     id_scan_out,
    input  logic [ID_LEN:0]       enable_tag,
    output logic                  ready,
    input  logic [PSUM_WIDTH:0]   master_enable_data [PE_NUMS],
    output logic [PE_NUMS-1:0]    master_ready,
    output logic                  out_valid,
    output logic [PSUM_WIDTH-1:0] out_data,
    output logic                  out_err,
    input  logic                  out_ready
);

    localparam int SEL_W = (PE_NUMS > 1) ? $clog2(PE_NUMS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            state;
    logic [ID_LEN-1:0] id_reg [PE_NUMS];
    logic [SEL_W-1:0]  sel;
    logic [SEL_W-1:0]  match_sel;
    logic              match_hit;
    logic              pe_valid;
    logic              req_en;
    logic [ID_LEN-1:0] req_tag;

`ifdef GON_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;
`endif

    assign req_en      = enable_tag[ID_LEN];
    assign req_tag     = enable_tag[ID_LEN-1:0];
    assign id_scan_out = id_reg[0];
    assign ready       = (state == S_IDLE) && !set_id;
    assign out_valid   = (state == S_HOLD);
    assign pe_valid    = master_enable_data[sel][PSUM_WIDTH];

    // ID chain shifts toward index 0; keeps shifting in any state because
    // the in-flight transaction works from the latched sel, not the IDs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PE_NUMS; i++) id_reg[i] <= '0;
        end else if (set_id) begin
            for (int i = 0; i < PE_NUMS - 1; i++) id_reg[i] <= id_reg[i+1];
            id_reg[PE_NUMS-1] <= id_scan_in;
        end
    end

    // Descending scan so the lowest matching index wins.
    always_comb begin
        match_hit = 1'b0;
        match_sel = '0;
        for (int i = PE_NUMS - 1; i >= 0; i--) begin
            if (id_reg[i] == req_tag) begin
                match_hit = 1'b1;
                match_sel = SEL_W'(i);
            end
        end
    end

    // Pop strobe follows the selected PE's valid in the same cycle.
    always_comb begin
        master_ready = '0;
        if (state == S_WAIT) master_ready[sel] = pe_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            sel      <= '0;
            out_data <= '0;
            out_err  <= 1'b0;
`ifdef GON_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (ready && req_en) begin
                        if (match_hit) begin
                            sel   <= match_sel;
                            state <= S_WAIT;
`ifdef GON_TIMEOUT_EN
                            tmo_cnt <= TMO_W'(TIMEOUT);
`endif
                        end else begin
                            out_data <= '0;
                            out_err  <= 1'b1;
                            state    <= S_HOLD;
                        end
                    end
                end
                S_WAIT: begin
                    if (pe_valid) begin
                        out_data <= master_enable_data[sel][PSUM_WIDTH-1:0];
                        out_err  <= 1'b0;
                        state    <= S_HOLD;
                    end
`ifdef GON_TIMEOUT_EN
                    else if (tmo_cnt == '0) begin
                        out_data <= '0;
                        out_err  <= 1'b1;
                        state    <= S_HOLD;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
`endif
                end
                S_HOLD: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gon_bus.sv
module tb_gon_bus;

    localparam int PE_NUMS    = 14;
    localparam int ID_LEN     = 4;
    localparam int PSUM_WIDTH = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  set_id;
    logic [ID_LEN-1:0]     id_scan_in;
    logic [ID_LEN-1:0]     id_scan_out;
    logic [ID_LEN:0]       enable_tag;
    logic                  ready;
    logic [PSUM_WIDTH:0]   pe_data [PE_NUMS];
    logic [PE_NUMS-1:0]    master_ready;
    logic                  out_valid;
    logic [PSUM_WIDTH-1:0] out_data;
    logic                  out_err;
    logic                  out_ready;

    int n_chk = 0;
    int n_bad = 0;

    gon_bus #(
        .PE_NUMS(PE_NUMS), .ID_LEN(ID_LEN), .PSUM_WIDTH(PSUM_WIDTH), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst), .set_id(set_id), .id_scan_in(id_scan_in),
        .id_scan_out(id_scan_out), .enable_tag(enable_tag), .ready(ready),
        .master_enable_data(pe_data), .master_ready(master_ready),
        .out_valid(out_valid), .out_data(out_data), .out_err(out_err),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a request for one cycle; returns after the accepting edge.
    task automatic send_req(input logic [ID_LEN-1:0] tag);
        enable_tag = {1'b1, tag};
        #1 chk("req_ready", ready, 1);
        @(negedge clk);
        enable_tag = '0;
    endtask

    initial begin
        int quiet;
        rst        = 1'b1;
        set_id     = 1'b0;
        id_scan_in = '0;
        enable_tag = '0;
        out_ready  = 1'b0;
        for (int i = 0; i < PE_NUMS; i++) pe_data[i] = '0;

        // reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mready", master_ready, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_scan_out", id_scan_out, 0);
        chk("rst_ready", ready, 1);
        @(negedge clk);
        rst = 1'b0;

        // scan 6..0,6..0: PE i ends up with 6-(i%7)
        for (int s = 0; s < 14; s++) begin
            set_id = 1'b1;
            id_scan_in = ID_LEN'(6 - (s % 7));
            #1 if (s == 0) chk("ready_during_scan", ready, 0);
            @(negedge clk);
            chk("scan1_out", id_scan_out, (s == 13) ? 6 : 0);
        end
        // reloading the same pattern walks the stored IDs out of id_scan_out
        for (int k = 1; k <= 14; k++) begin
            id_scan_in = ID_LEN'(6 - ((k - 1) % 7));
            @(negedge clk);
            chk("scan2_out", id_scan_out, 6 - (k % 7));
        end
        set_id = 1'b0;

        // tag 3 -> PE3 (also PE10, higher index, must be ignored)
        pe_data[3]  = {1'b1, 32'h0000_00A5};
        pe_data[10] = {1'b1, 32'h0000_0077};
        send_req(4'd3);
        chk("a_wait_mready", master_ready, 14'h0008);
        chk("a_wait_ovalid", out_valid, 0);
        chk("a_wait_ready", ready, 0);
        @(negedge clk);
        pe_data[3] = '0;
        chk("a_hold_mready", master_ready, 0);
        chk("a_hold_ovalid", out_valid, 1);
        chk("a_hold_data", out_data, 32'hA5);
        chk("a_hold_err", out_err, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("a_done_ready", ready, 1);
        chk("a_done_ovalid", out_valid, 0);
        chk("a_done_mready", master_ready, 0);
        pe_data[10] = '0;

        // tag 2 -> PE4, valid 5 cycles late, out_ready held low 3 cycles
        send_req(4'd2);
        for (int c = 0; c < 5; c++) begin
            chk("b_wait_state", {ready, out_valid, master_ready}, 16'h0000);
            @(negedge clk);
        end
        pe_data[4] = {1'b1, 32'hCAFE_0002};
        #1 chk("b_pop_mready", master_ready, 14'h0010);
        @(negedge clk);
        pe_data[4] = '0;
        for (int c = 0; c < 3; c++) begin
            chk("b_hold_data", out_data, 32'hCAFE_0002);
            chk("b_hold_flags", {ready, out_valid, out_err, master_ready}, 17'h08000);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 chk("b_hs_ready", ready, 0);
        @(negedge clk);
        out_ready = 1'b0;
        chk("b_after_ready", ready, 1);
        chk("b_after_ovalid", out_valid, 0);

        // tag 15 -> no match, error response, nothing popped
        pe_data[0] = {1'b1, 32'h1111_1111};
        send_req(4'd15);
        chk("c_ovalid", out_valid, 1);
        chk("c_err", out_err, 1);
        chk("c_data", out_data, 0);
        chk("c_mready", master_ready, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        pe_data[0] = '0;
        chk("c_ready", ready, 1);

        // tag 0 -> PE6, never valid
        send_req(4'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("d_wait_ovalid", out_valid, 0);
        end
        @(negedge clk);
`ifdef GON_TIMEOUT_EN
        chk("d_tmo_ovalid", out_valid, 1);
        chk("d_tmo_err", out_err, 1);
        chk("d_tmo_data", out_data, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
`else
        chk("d_still_wait", out_valid, 0);
        quiet = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid === 1'b0 && master_ready === '0) quiet++;
        end
        chk("d_quiet_cycles", quiet, 20);
        pe_data[6] = {1'b1, 32'h0000_0055};
        #1 chk("d_pop_mready", master_ready, 14'h0040);
        @(negedge clk);
        pe_data[6] = '0;
        chk("d_data", out_data, 32'h55);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
`endif
        chk("d_ready", ready, 1);

        // tag 0 -> PE6; shifting mid-WAIT moves an ID 0 to PE4 but sel stays 6
        send_req(4'd0);
        set_id = 1'b1;
        id_scan_in = 4'd9;
        @(negedge clk);
        @(negedge clk);
        set_id = 1'b0;
        pe_data[4] = {1'b1, 32'h0000_BEEF};
        pe_data[6] = {1'b1, 32'h0000_1234};
        #1 chk("e_mready", master_ready, 14'h0040);
        @(negedge clk);
        pe_data[4] = '0;
        pe_data[6] = '0;
        chk("e_ovalid", out_valid, 1);
        chk("e_data", out_data, 32'h1234);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // chain is now ...,PE12=9,PE13=9; tag 9 -> PE12, reset mid-WAIT
        send_req(4'd9);
        chk("f_in_wait", {out_valid, ready}, 2'b00);
        #2 rst = 1'b1;
        #1;
        chk("f_rst_ovalid", out_valid, 0);
        chk("f_rst_data", out_data, 0);
        chk("f_rst_err", out_err, 0);
        chk("f_rst_mready", master_ready, 0);
        chk("f_rst_scan", id_scan_out, 0);
        pe_data[12] = {1'b1, 32'h0000_00EE};
        @(posedge clk);
        #1 chk("f_rst_edge_mready", master_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("f_after_mready", master_ready, 0);
        chk("f_after_ovalid", out_valid, 0);
        pe_data[12] = '0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
